// File: rtl/cbp_pipelined_subtractor.sv
// Pipelined subtractor: Diff = A - B - Bin, one carry-bypass chunk resolved per stage.
// Operands skew through the stage registers while the borrow chain ripples chunk by chunk.

module cbp_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] rip;
  logic       p;

  assign rip  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
  // every bit propagates: the chunk is transparent to the incoming carry
  assign p    = &(a ^ ~b);
  assign s    = rip[W-1:0];
  assign cout = p ? cin : rip[W];
endmodule

module cbp_pipelined_subtractor #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic                Bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] Diff,
  output logic                Bout,
  output logic                Ovf,
  output logic                Zero
);
  localparam int W   = NUM_BITS / NUM_STAGES;
  localparam int MSB = NUM_BITS - 1;

  if (NUM_BITS % NUM_STAGES != 0) begin : g_bad_split
    $error("NUM_BITS must be a multiple of NUM_STAGES");
  end

  typedef struct packed {
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic [NUM_BITS-1:0] d;
    logic                c;
    logic                am;
    logic                bm;
  } stage_t;

  stage_t [NUM_STAGES-1:0]        st, st_nxt;
  stage_t                         lst;
  logic   [NUM_STAGES:1]          vld_pipe;
  logic   [NUM_STAGES-1:0][W-1:0] ch_s;
  logic   [NUM_STAGES-1:0]        ch_c;
  logic                           bout_r, ovf_r, zero_r;
  logic                           bout_n, ovf_n, zero_n;
  logic                           adv;

  assign out_valid = vld_pipe[NUM_STAGES];
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_lane
    logic [W-1:0] ca, cb;
    logic         ci;
    if (i == 0) begin : g_head
      assign ca = A[W-1:0];
      assign cb = B[W-1:0];
      assign ci = ~Bin;
    end else begin : g_body
      assign ca = st[i-1].a[i*W +: W];
      assign cb = st[i-1].b[i*W +: W];
      assign ci = st[i-1].c;
    end
    cbp_chunk #(.W(W)) u_chunk (
      .a   (ca),
      .b   (cb),
      .cin (ci),
      .s   (ch_s[i]),
      .cout(ch_c[i])
    );
  end

  always_comb begin
    st_nxt            = st;
    st_nxt[0].a       = A;
    st_nxt[0].b       = B;
    st_nxt[0].d       = '0;
    st_nxt[0].d[W-1:0] = ch_s[0];
    st_nxt[0].c       = ch_c[0];
    st_nxt[0].am      = A[MSB];
    st_nxt[0].bm      = B[MSB];
    for (int i = 1; i < NUM_STAGES; i++) begin
      st_nxt[i]              = st[i-1];
      st_nxt[i].d[i*W +: W]  = ch_s[i];
      st_nxt[i].c            = ch_c[i];
    end
  end

  // flags are registered alongside the final chunk so they stay aligned with Diff
  assign lst    = st_nxt[NUM_STAGES-1];
  assign zero_n = ~|lst.d;
  assign bout_n = ~lst.c;
  assign ovf_n  = (lst.am ^ lst.bm) & (lst.d[MSB] ^ lst.am);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= '0;
      vld_pipe <= '0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else if (adv) begin
      st          <= st_nxt;
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= NUM_STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      bout_r      <= bout_n;
      ovf_r       <= ovf_n;
      zero_r      <= zero_n;
    end
  end

  assign Diff = st[NUM_STAGES-1].d;
  assign Bout = bout_r;
  assign Ovf  = ovf_r;
  assign Zero = zero_r;
endmodule

// File: tb/tb_cbp_pipelined_subtractor.sv
// Bench for cbp_pipelined_subtractor: arithmetic scoreboard plus directed literal vectors.
module tb_cbp_pipelined_subtractor;
  localparam int NB = 32;
  localparam int NS = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1, Bin = 1'b0;
  logic [NB-1:0] A = '0, B = '0;
  logic          in_ready, out_valid, Bout, Ovf, Zero;
  logic [NB-1:0] Diff;

  cbp_pipelined_subtractor #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] d;
    logic          bout, ovf, zero;
    int            t;
  } exp_t;

  exp_t          q[$];
  exp_t          ce;
  int            n_chk = 0, n_fail = 0, cyc = 0;
  bit            lat_chk = 0, prev_stall = 0;
  logic [NB-1:0] pd;
  logic          pb, po, pz;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic bin);
    exp_t        e;
    logic [NB:0] full;
    longint      sd;
    full   = {1'b0, a} - {1'b0, b} - 33'(bin);
    sd     = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    e.d    = full[NB-1:0];
    e.bout = ({1'b0, a} < ({1'b0, b} + 33'(bin)));
    e.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    e.zero = (e.d == 0);
    e.t    = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      chk("in_ready_rule", in_ready, out_ready || !out_valid);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_diff", Diff, pd);
        chk("stall_flags", {Bout, Ovf, Zero}, {pb, po, pz});
      end
      if (out_valid && out_ready) begin
        chk("extra_beat", q.size() == 0, 0);
        if (q.size() > 0) begin
          ce = q.pop_front();
          chk("sb_diff", Diff, ce.d);
          chk("sb_bout", Bout, ce.bout);
          chk("sb_ovf", Ovf, ce.ovf);
          chk("sb_zero", Zero, ce.zero);
          if (lat_chk) chk("latency", cyc - ce.t, NS);
        end
      end
      if (in_valid && in_ready) begin
        ce   = model(A, B, Bin);
        ce.t = cyc;
        q.push_back(ce);
      end
      prev_stall = out_valid && !out_ready;
      pd = Diff; pb = Bout; po = Ovf; pz = Zero;
    end
  end

  // called at posedge+1 with out_ready=1 and an empty pipeline
  task automatic send_chk(input string nm, input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic bin, input logic [NB-1:0] ed, input logic eb,
                          input logic eo, input logic ez);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk({nm, "_early"}, out_valid, 0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_diff"}, Diff, ed);
    chk({nm, "_bout"}, Bout, eb);
    chk({nm, "_ovf"}, Ovf, eo);
    chk({nm, "_zero"}, Zero, ez);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pat[6];
    bit  obs[12];
    int  sent, cc, cnt;
    bit  acc;
    pat = '{1, 0, 1, 1, 0, 1};

    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_flags", {Bout, Ovf, Zero}, 3'b000);
    #20 rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    lat_chk = 1;
    send_chk("basic", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
    send_chk("wrap", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_chk("eq_bin", 32'h5, 32'h5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_chk("eq_zero", 32'h5, 32'h5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send_chk("ovf_neg", 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_chk("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 6) ? pat[k][0] : 1'b0;
      A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      @(negedge clk) obs[k] = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++)
      chk($sformatf("bubble_%0d", k), obs[k], (k >= 4 && k < 10) ? pat[k-4][0] : 1'b0);

    lat_chk = 0;
    sent = 0; cc = 0;
    in_valid = 1'b1;
    A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
    while (sent < 20 && cc < 2000) begin
      out_ready = (cc >= 8 && cc <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk) acc = in_ready;
      @(posedge clk); #1;
      cc++;
      if (acc) begin
        sent++;
        A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sent", sent, 20);
    cnt = 0;
    while (q.size() > 0 && cnt < 100) begin
      @(posedge clk); cnt++;
    end
    #1 chk("stream_drain", q.size(), 0);
    @(posedge clk); #1;

    lat_chk = 1;
    A = 32'h10; B = 32'h1; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 A = 32'h20;
    @(posedge clk); #1 A = 32'h30;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_diff", Diff, 0);
    chk("mid_rst_flags", {Bout, Ovf, Zero}, 3'b000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    send_chk("post_rst", 32'h100, 32'h1, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 chk("final_queue", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
